// File: rtl/mmio_bridge.sv
// Data-side bridge from the EX_DM stage to internal data memory or NUM_CH external
// peripheral channels, with ready handshake, pipeline stall, timeout and a sticky bus error.
module mmio_bridge #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_stall,
    output logic                     dm_we,
    output logic                     dm_re,
    input  logic [DATA_W-1:0]        dm_rdata,
    output logic [ADDR_W-1:0]        ext_addr,
    output logic [DATA_W-1:0]        ext_wdata,
    output logic [NUM_CH-1:0]        ext_we,
    output logic [NUM_CH-1:0]        ext_re,
    input  logic [NUM_CH*DATA_W-1:0] ext_rdata,
    input  logic [NUM_CH-1:0]        ext_rdy,
    input  logic                     err_clr,
    output logic                     bus_err,
    output logic [ADDR_W-1:0]        err_addr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic                req_s;
    logic                int_s;
    logic                ext_s;
    logic                hole_s;
    logic [CH_BITS-1:0]  ch_s;
    logic                ch_ok_s;
    logic [NUM_CH-1:0]   onehot_s;
    logic [DATA_W-1:0]   sel_rdata_s;
    logic                sel_rdy_s;
    logic                cnt_last_s;
    logic                err_evt_s;
    logic [ADDR_W-1:0]   err_addr_new_s;

    logic [CH_BITS-1:0]  ch_r;
    logic                dir_we_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   cap_r;
    logic [ADDR_W-1:0]   ext_addr_r;
    logic [DATA_W-1:0]   ext_wdata_r;
    logic [NUM_CH-1:0]   ext_we_r;
    logic [NUM_CH-1:0]   ext_re_r;
    logic                bus_err_r;
    logic [ADDR_W-1:0]   err_addr_r;

    assign req_s      = cpu_we | cpu_re;
    assign int_s      = (cpu_addr[ADDR_W-1 -: 4] == 4'b0000);
    assign ext_s      = (cpu_addr[ADDR_W-1 -: 2] == 2'b11);
    assign hole_s     = ~int_s & ~ext_s;
    assign ch_s       = cpu_addr[ADDR_W-3 -: CH_BITS];
    assign ch_ok_s    = ({1'b0, ch_s} < (CH_BITS+1)'(NUM_CH));
    assign cnt_last_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Channel muxing: strobe one-hot for the new request, data/ready of the latched channel
    always_comb begin
        onehot_s    = '0;
        sel_rdata_s = '0;
        sel_rdy_s   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            onehot_s[i] = (ch_s == CH_BITS'(i));
            sel_rdata_s = sel_rdata_s
                        | (ext_rdata[i*DATA_W +: DATA_W] & {DATA_W{ch_r == CH_BITS'(i)}});
            sel_rdy_s   = sel_rdy_s | (ext_rdy[i] & (ch_r == CH_BITS'(i)));
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (ext_s && req_s) begin
                    state_nxt_s = ch_ok_s ? ST_WAIT : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sel_rdy_s || cnt_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stall, load-data mux and internal DM enables (DONE suppresses re-decode)
    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        dm_we     = 1'b0;
        dm_re     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cpu_stall = ext_s & req_s;
                dm_we     = cpu_we & int_s;
                dm_re     = cpu_re & int_s & ~cpu_we;
                if (int_s) begin
                    cpu_rdata = dm_rdata;
                end else begin
                    cpu_rdata = '0;
                end
            end
            ST_WAIT: cpu_stall = 1'b1;
            ST_DONE: cpu_rdata = cap_r;
            default: cpu_stall = 1'b0;
        endcase
    end

    // Error event decode: hole access, unpopulated channel, or handshake timeout
    always_comb begin
        err_evt_s      = 1'b0;
        err_addr_new_s = cpu_addr;
        if (state_r == ST_IDLE && req_s && (hole_s || (ext_s && !ch_ok_s))) begin
            err_evt_s      = 1'b1;
            err_addr_new_s = cpu_addr;
        end else if (state_r == ST_WAIT && !sel_rdy_s && cnt_last_s) begin
            err_evt_s      = 1'b1;
            err_addr_new_s = ext_addr_r;
        end else begin
            err_evt_s      = 1'b0;
            err_addr_new_s = cpu_addr;
        end
    end

    // Transaction datapath: latch request, drive strobes, count WAIT cycles, capture data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_r        <= '0;
            dir_we_r    <= 1'b0;
            cnt_r       <= '0;
            cap_r       <= '0;
            ext_addr_r  <= '0;
            ext_wdata_r <= '0;
            ext_we_r    <= '0;
            ext_re_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ext_s && req_s) begin
                        if (ch_ok_s) begin
                            ch_r        <= ch_s;
                            dir_we_r    <= cpu_we;
                            cnt_r       <= '0;
                            ext_addr_r  <= cpu_addr;
                            ext_wdata_r <= cpu_wdata;
                            ext_we_r    <= cpu_we ? onehot_s : '0;
                            ext_re_r    <= cpu_we ? '0 : onehot_s;
                        end else begin
                            cap_r <= '1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sel_rdy_s) begin
                        ext_we_r <= '0;
                        ext_re_r <= '0;
                        if (!dir_we_r) begin
                            cap_r <= sel_rdata_s;
                        end
                    end else if (cnt_last_s) begin
                        ext_we_r <= '0;
                        ext_re_r <= '0;
                        cap_r    <= '1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    ext_we_r <= '0;
                    ext_re_r <= '0;
                end
            endcase
        end
    end

    // Sticky error flag; a new error on the same edge as err_clr wins and re-captures the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= '0;
        end else if (err_evt_s) begin
            bus_err_r <= 1'b1;
            if (!bus_err_r || err_clr) begin
                err_addr_r <= err_addr_new_s;
            end
        end else if (err_clr) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= '0;
        end
    end

    assign ext_addr  = ext_addr_r;
    assign ext_wdata = ext_wdata_r;
    assign ext_we    = ext_we_r;
    assign ext_re    = ext_re_r;
    assign bus_err   = bus_err_r;
    assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge (NUM_CH = 3, so channel 3 is unpopulated).
module tb_mmio_bridge;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NC = 3;
    localparam int CB = 2;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            cpu_we;
    logic            cpu_re;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_stall;
    logic            dm_we;
    logic            dm_re;
    logic [DW-1:0]   dm_rdata;
    logic [AW-1:0]   ext_addr;
    logic [DW-1:0]   ext_wdata;
    logic [NC-1:0]   ext_we;
    logic [NC-1:0]   ext_re;
    logic [NC*DW-1:0] ext_rdata;
    logic [NC-1:0]   ext_rdy;
    logic            err_clr;
    logic            bus_err;
    logic [AW-1:0]   err_addr;

    logic [DW-1:0]   dm_mem [0:255];
    int              pass_cnt = 0;
    int              total_cnt = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .CH_BITS(CB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dm_we(dm_we), .dm_re(dm_re), .dm_rdata(dm_rdata), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_re(ext_re), .ext_rdata(ext_rdata),
        .ext_rdy(ext_rdy), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
    );

    always @(posedge clk) begin
        if (dm_we) dm_mem[cpu_addr[7:0]] <= cpu_wdata;
    end
    assign dm_rdata = dm_mem[cpu_addr[7:0]];

    task automatic idle_inputs();
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", cpu_stall); else pass_cnt++;
        total_cnt++; if (ext_we !== 3'b000 || ext_re !== 3'b000) $display("FAIL reset_strobes got we=%b re=%b want 000", ext_we, ext_re); else pass_cnt++;
        total_cnt++; if (ext_addr !== 16'h0000 || ext_wdata !== 16'h0000) $display("FAIL reset_ext_bus got %h/%h want 0000/0000", ext_addr, ext_wdata); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b0 || err_addr !== 16'h0000) $display("FAIL reset_err got %0b/%h want 0/0000", bus_err, err_addr); else pass_cnt++;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_internal();
        @(posedge clk); #1 cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h0ABC;
        @(negedge clk);
        total_cnt++; if (dm_we !== 1'b1 || dm_re !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL int_store got we=%0b re=%0b stall=%0b want 1/0/0", dm_we, dm_re, cpu_stall); else pass_cnt++;
        @(posedge clk); #1 cpu_we = 1'b0; cpu_re = 1'b1;
        @(negedge clk);
        total_cnt++; if (dm_we !== 1'b0 || dm_re !== 1'b1 || cpu_stall !== 1'b0) $display("FAIL int_load_ctl got we=%0b re=%0b stall=%0b want 0/1/0", dm_we, dm_re, cpu_stall); else pass_cnt++;
        total_cnt++; if (cpu_rdata !== 16'h0ABC) $display("FAIL int_load_data got %h want 0abc", cpu_rdata); else pass_cnt++;
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_ext_fast();
        int n_stall = 0; int n_str = 0; int bad = 0; bit done = 1'b0; logic [DW-1:0] rd = '0;
        ext_rdy = 3'b001; ext_rdata[0 +: DW] = 16'h1234;
        @(posedge clk); #1 cpu_re = 1'b1; cpu_addr = 16'hC002;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cpu_stall) begin
                n_stall++;
                if (ext_re === 3'b001) n_str++; else if (ext_re !== 3'b000) bad++;
            end else begin
                done = 1'b1; rd = cpu_rdata;
                if (ext_re !== 3'b000) bad++;
            end
        end
        total_cnt++; if (!done || n_stall != 2) $display("FAIL fast_stall got %0d cycles (done=%0b) want 2", n_stall, done); else pass_cnt++;
        total_cnt++; if (n_str != 1 || bad != 0) $display("FAIL fast_strobe got %0d cycles bad=%0d want 1/0", n_str, bad); else pass_cnt++;
        total_cnt++; if (rd !== 16'h1234) $display("FAIL fast_rdata got %h want 1234", rd); else pass_cnt++;
        total_cnt++; if (ext_addr !== 16'hC002) $display("FAIL fast_addr got %h want c002", ext_addr); else pass_cnt++;
        @(posedge clk); #1 idle_inputs(); ext_rdy = 3'b000;
    endtask

    task automatic test_ext_slow();
        int n_stall = 0; int n_str = 0; int bad = 0; bit done = 1'b0;
        ext_rdy = 3'b000;
        @(posedge clk); #1 cpu_we = 1'b1; cpu_addr = 16'hD000; cpu_wdata = 16'h55AA;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cpu_stall) begin
                n_stall++;
                if (ext_we === 3'b010) begin
                    n_str++;
                    if (ext_wdata !== 16'h55AA || ext_addr !== 16'hD000) bad++;
                end else if (n_stall > 1 || ext_we !== 3'b000) begin
                    bad++;
                end
                if (n_str == 4 && ext_rdy == 3'b000) begin
                    @(posedge clk); #1 ext_rdy[1] = 1'b1;
                end
            end else begin
                done = 1'b1;
                if (ext_we !== 3'b000 || ext_re !== 3'b000) bad++;
            end
        end
        total_cnt++; if (!done || n_stall != 6) $display("FAIL slow_stall got %0d cycles (done=%0b) want 6", n_stall, done); else pass_cnt++;
        total_cnt++; if (n_str != 5) $display("FAIL slow_strobe got %0d cycles want 5", n_str); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL slow_bus_stable got %0d bad cycles want 0", bad); else pass_cnt++;
        @(posedge clk); #1 idle_inputs(); ext_rdy = 3'b000;
    endtask

    task automatic test_timeout();
        for (int t = 0; t < 2; t++) begin
            int n_stall = 0; int n_str = 0; bit done = 1'b0; logic [DW-1:0] rd = '0;
            @(posedge clk); #1 cpu_re = 1'b1; cpu_addr = (t == 0) ? 16'hE000 : 16'hE004;
            for (int i = 0; i < 60 && !done; i++) begin
                @(negedge clk);
                if (cpu_stall) begin
                    n_stall++;
                    if (ext_re === 3'b100) n_str++;
                end else begin
                    done = 1'b1; rd = cpu_rdata;
                end
            end
            total_cnt++; if (!done || n_str != 15 || n_stall != 16) $display("FAIL timeout_len[%0d] got strobe=%0d stall=%0d want 15/16", t, n_str, n_stall); else pass_cnt++;
            total_cnt++; if (rd !== 16'hFFFF) $display("FAIL timeout_rdata[%0d] got %h want ffff", t, rd); else pass_cnt++;
            total_cnt++; if (bus_err !== 1'b1 || err_addr !== 16'hE000) $display("FAIL timeout_err[%0d] got %0b/%h want 1/e000", t, bus_err, err_addr); else pass_cnt++;
            @(posedge clk); #1 idle_inputs();
        end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus_err !== 1'b0 || err_addr !== 16'h0000) $display("FAIL err_clr got %0b/%h want 0/0000", bus_err, err_addr); else pass_cnt++;
    endtask

    task automatic test_hole_unpop();
        @(posedge clk); #1 cpu_re = 1'b1; cpu_addr = 16'h4000;
        @(negedge clk);
        total_cnt++; if (cpu_stall !== 1'b0 || cpu_rdata !== 16'h0000 || dm_re !== 1'b0) $display("FAIL hole_access got stall=%0b rdata=%h dm_re=%0b want 0/0000/0", cpu_stall, cpu_rdata, dm_re); else pass_cnt++;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        total_cnt++; if (bus_err !== 1'b1 || err_addr !== 16'h4000) $display("FAIL hole_err got %0b/%h want 1/4000", bus_err, err_addr); else pass_cnt++;
        // unpopulated channel together with err_clr: the new error must win
        @(posedge clk); #1 cpu_re = 1'b1; cpu_addr = 16'hF000; err_clr = 1'b1;
        @(negedge clk);
        total_cnt++; if (cpu_stall !== 1'b1 || ext_re !== 3'b000 || ext_we !== 3'b000) $display("FAIL unpop_idle got stall=%0b re=%b we=%b want 1/000/000", cpu_stall, ext_re, ext_we); else pass_cnt++;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        total_cnt++; if (cpu_stall !== 1'b0 || cpu_rdata !== 16'hFFFF || ext_re !== 3'b000) $display("FAIL unpop_done got stall=%0b rdata=%h re=%b want 0/ffff/000", cpu_stall, cpu_rdata, ext_re); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b1 || err_addr !== 16'hF000) $display("FAIL unpop_err got %0b/%h want 1/f000", bus_err, err_addr); else pass_cnt++;
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        int n_stall = 0; bit done = 1'b0; logic [DW-1:0] rd = '0;
        ext_rdy = 3'b000;
        @(posedge clk); #1 cpu_re = 1'b1; cpu_addr = 16'hC000;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (ext_re !== 3'b001) $display("FAIL rst_pre_wait got re=%b want 001", ext_re); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (ext_re !== 3'b000) $display("FAIL rst_async_strobe got re=%b want 000", ext_re); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b0 || err_addr !== 16'h0000) $display("FAIL rst_async_err got %0b/%h want 0/0000", bus_err, err_addr); else pass_cnt++;
        idle_inputs();
        #1;
        total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", cpu_stall); else pass_cnt++;
        @(posedge clk); #1 rst_n = 1'b1;
        ext_rdy = 3'b100; ext_rdata[2*DW +: DW] = 16'hBEEF;
        @(posedge clk); #1 cpu_re = 1'b1; cpu_addr = 16'hE000;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cpu_stall) n_stall++; else begin done = 1'b1; rd = cpu_rdata; end
        end
        total_cnt++; if (!done || n_stall != 2 || rd !== 16'hBEEF) $display("FAIL rst_next_access got stall=%0d rdata=%h want 2/beef", n_stall, rd); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL rst_next_err got %0b want 0", bus_err); else pass_cnt++;
        @(posedge clk); #1 idle_inputs(); ext_rdy = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dm_mem[i] = 16'h0000;
        idle_inputs();
        ext_rdy = 3'b000; ext_rdata = '0; err_clr = 1'b0;
        test_reset();
        test_internal();
        test_ext_fast();
        test_ext_slow();
        test_timeout();
        test_hole_unpop();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
